// File: rtl/edge_mag_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : edge_mag_buffer
//  Description : Gradient-magnitude edge detector feeding a result buffer.
//                Fill mode computes |dLR| + |dUD| against the previous
//                sample (optionally thresholded to a binary edge map) and
//                stores it. Drain mode streams the stored words back out.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_mag_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int THRESH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resetBuff,
  input  logic              enb,
  input  logic              buffMode,
  input  logic [DATA_W-1:0] upDownArray,
  input  logic [DATA_W-1:0] leftRightArray,
  output logic [DATA_W-1:0] OutArray,
  output logic              outValid,
  output logic              complete,
  output logic              full,
  output logic              overflow
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_ONE   = (c_AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_AW:0]       count_q, count_d;
  logic [c_AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0]   ud_prev_q, ud_prev_d;
  logic                has_prev_q, has_prev_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                complete_q, complete_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   w_lr_diff, w_ud_diff, w_mag, w_store;
  logic [DATA_W:0]     w_sum;
  logic                w_wr_en;
  logic                w_full;

  // Absolute differences against the previous accepted sample, summed one bit
  // wider and saturated back to DATA_W. The first sample has no predecessor.
  always_comb begin
    w_lr_diff = (leftRightArray >= lr_prev_q) ? (leftRightArray - lr_prev_q)
                                              : (lr_prev_q - leftRightArray);
    w_ud_diff = (upDownArray >= ud_prev_q) ? (upDownArray - ud_prev_q)
                                           : (ud_prev_q - upDownArray);
    w_sum     = {1'b0, w_lr_diff} + {1'b0, w_ud_diff};
    if (!has_prev_q)
      w_mag = '0;
    else if (w_sum[DATA_W])
      w_mag = '1;
    else
      w_mag = w_sum[DATA_W-1:0];
  end

  generate
    if (THRESH > 0) begin : g_thresh
      localparam logic [DATA_W:0] c_THRESH = (DATA_W+1)'(THRESH);
      assign w_store = ({1'b0, w_mag} >= c_THRESH) ? '1 : '0;
    end else begin : g_mag
      assign w_store = w_mag;
    end
  endgenerate

  assign w_full = (count_q == c_DEPTH);

  // Next-state logic: mode transitions, fill acceptance and drain stepping.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    lr_prev_d  = lr_prev_q;
    ud_prev_d  = ud_prev_q;
    has_prev_d = has_prev_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    complete_d = complete_q;
    overflow_d = overflow_q;
    w_wr_en    = 1'b0;

    if (resetBuff) begin
      state_d    = S_IDLE;
      count_d    = '0;
      rd_ptr_d   = '0;
      lr_prev_d  = '0;
      ud_prev_d  = '0;
      has_prev_d = 1'b0;
      out_d      = '0;
      complete_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FILL: begin
          if (enb) begin
            if (!buffMode) begin
              state_d = S_FILL;
              if (w_full) begin
                overflow_d = 1'b1;
              end else begin
                w_wr_en    = 1'b1;
                count_d    = count_q + c_ONE;
                lr_prev_d  = leftRightArray;
                ud_prev_d  = upDownArray;
                has_prev_d = 1'b1;
              end
            end else begin
              state_d  = S_DRAIN;
              rd_ptr_d = '0;
            end
          end
        end
        S_DRAIN: begin
          if (enb) begin
            if (rd_ptr_q < count_q) begin
              out_d    = mem_q[rd_ptr_q[c_AW-1:0]];
              valid_d  = 1'b1;
              rd_ptr_d = rd_ptr_q + c_ONE;
            end else begin
              state_d    = S_DONE;
              complete_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_DONE;
        end
      endcase
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      lr_prev_q  <= '0;
      ud_prev_q  <= '0;
      has_prev_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      lr_prev_q  <= lr_prev_d;
      ud_prev_q  <= ud_prev_d;
      has_prev_q <= has_prev_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
    end
  end

  // Result storage; contents are deliberately left untouched by any reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset)
      mem_q[count_q[c_AW-1:0]] <= w_store;
  end

  assign OutArray = out_q;
  assign outValid = valid_q;
  assign complete = complete_q;
  assign full     = w_full;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_mag_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_mag_buffer
//  Description : Self-checking bench for edge_mag_buffer (DEPTH=4), with a
//                second instance using THRESH=8 for the binary edge map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_mag_buffer;

  logic       clk = 1'b0;
  logic       reset, resetBuff, enb, buffMode;
  logic [7:0] upDownArray, leftRightArray;
  logic [7:0] out0, out1;
  logic       vld0, vld1, cmp0, cmp1, full0, full1, ovf0, ovf1;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  bit ovf   = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  edge_mag_buffer #(.DATA_W(8), .DEPTH(4), .THRESH(0)) u_dut0 (
    .clk(clk), .reset(reset), .resetBuff(resetBuff), .enb(enb),
    .buffMode(buffMode), .upDownArray(upDownArray),
    .leftRightArray(leftRightArray), .OutArray(out0), .outValid(vld0),
    .complete(cmp0), .full(full0), .overflow(ovf0)
  );

  edge_mag_buffer #(.DATA_W(8), .DEPTH(4), .THRESH(8)) u_dut1 (
    .clk(clk), .reset(reset), .resetBuff(resetBuff), .enb(enb),
    .buffMode(buffMode), .upDownArray(upDownArray),
    .leftRightArray(leftRightArray), .OutArray(out1), .outValid(vld1),
    .complete(cmp1), .full(full1), .overflow(ovf1)
  );

  typedef struct {
    int         grp;
    logic [7:0] lr;
    logic [7:0] ud;
    logic [7:0] exp;
    bit         acc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_resetbuff();
    resetBuff = 1'b1;
    enb       = 1'b1;
    buffMode  = 1'b0;
    step();
    resetBuff = 1'b0;
    enb       = 1'b0;
    cnt = 0;
    ovf = 1'b0;
    chk("rb_out", out0, 0);
    chk("rb_valid", vld0, 0);
    chk("rb_complete", cmp0, 0);
    chk("rb_full", full0, 0);
    chk("rb_overflow", ovf0, 0);
  endtask

  // Apply every table row of a group as a fill sample and queue expectations.
  task automatic apply_group(input int g, input int sel);
    foreach (tbl[i]) begin
      if (tbl[i].grp == g) begin
        enb            = 1'b1;
        buffMode       = 1'b0;
        leftRightArray = tbl[i].lr;
        upDownArray    = tbl[i].ud;
        if (cnt == 4) ovf = 1'b1;
        else          cnt++;
        if (tbl[i].acc) begin
          if (sel == 0) q0.push_back(tbl[i].exp);
          else          q1.push_back(tbl[i].exp);
        end
        step();
        enb = 1'b0;
        chk("fill_full", full0, (cnt == 4) ? 1 : 0);
        chk("fill_overflow", ovf0, ovf ? 1 : 0);
      end
    end
  endtask

  task automatic drain_enter();
    enb      = 1'b1;
    buffMode = 1'b1;
    step();
    chk("enter_valid", vld0, 0);
  endtask

  task automatic drain_word(input int sel, output logic [7:0] got);
    logic [7:0] e;
    enb      = 1'b1;
    buffMode = 1'b1;
    step();
    got = (sel == 0) ? out0 : out1;
    chk("drain_valid", (sel == 0) ? vld0 : vld1, 1);
    if (((sel == 0) ? q0.size() : q1.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got word %0d expected none", got);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      chk("drain_data", got, e);
    end
  endtask

  task automatic drain_finish(input int sel);
    enb      = 1'b1;
    buffMode = 1'b1;
    step();
    chk("done_complete", (sel == 0) ? cmp0 : cmp1, 1);
    chk("done_valid", (sel == 0) ? vld0 : vld1, 0);
    chk("done_queue_left", (sel == 0) ? q0.size() : q1.size(), 0);
    enb = 1'b0;
  endtask

  task automatic drain(input int sel, input int n);
    logic [7:0] w;
    drain_enter();
    for (int i = 0; i < n; i++) drain_word(sel, w);
    drain_finish(sel);
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] w;

    tbl = '{
      '{1,  10,   0,   0, 1}, '{1,  20,   0,  10, 1},
      '{1,  15,   0,   5, 1}, '{1,  15,   0,   0, 1},
      '{2,   0,   0,   0, 1}, '{2, 255, 200, 255, 1},
      '{2, 255, 200,   0, 1}, '{2, 100,  50, 255, 1},
      '{3,   1,   1,   0, 1}, '{3,   3,   1,   2, 1},
      '{3,   7,   4,   7, 1}, '{3,   2,   4,   5, 1},
      '{3, 200,   9,   0, 0},
      '{4,  50,  50,   0, 1}, '{4,  60,  40,  20, 1},
      '{4,  60,  40,   0, 1}, '{4,   0,   0, 100, 1},
      '{5,   0,   0,   0, 1}, '{5,  30,   0,  30, 1},
      '{6,   5,   5,   0, 1}, '{6,   9,   5,   4, 1},
      '{7,   0,   0,   0, 1}, '{7,  10,   0, 255, 1},
      '{7,  15,   0,   0, 1}
    };

    reset = 1'b1; resetBuff = 1'b0; enb = 1'b0; buffMode = 1'b0;
    upDownArray = '0; leftRightArray = '0;
    #1;
    chk("rst_out", out0, 0);
    chk("rst_valid", vld0, 0);
    chk("rst_complete", cmp0, 0);
    chk("rst_full", full0, 0);
    chk("rst_overflow", ovf0, 0);
    step();
    reset = 1'b0;

    // Basic magnitude sequence, then DONE must ignore further fill requests.
    apply_group(1, 0);
    drain(0, 4);
    enb = 1'b1; buffMode = 1'b0;
    step();
    enb = 1'b0;
    chk("done_sticky", cmp0, 1);
    chk("done_no_fill_full", full0, 1);
    chk("done_no_fill_ovf", ovf0, 0);
    chk("done_no_valid", vld0, 0);
    do_resetbuff();

    // Saturation of large gradients.
    apply_group(2, 0);
    drain(0, 4);
    do_resetbuff();

    // Overflow: fifth sample discarded, only four words come back.
    apply_group(3, 0);
    drain(0, 4);
    chk("ovf_sticky", ovf0, 1);
    do_resetbuff();

    // Drain stalled by enb low for three cycles.
    apply_group(4, 0);
    drain_enter();
    drain_word(0, w);
    drain_word(0, held);
    for (int i = 0; i < 3; i++) begin
      enb = 1'b0;
      step();
      chk("stall_hold", out0, held);
      chk("stall_valid", vld0, 0);
    end
    drain_word(0, w);
    drain_word(0, w);
    drain_finish(0);
    do_resetbuff();

    // Asynchronous reset in the middle of a drain.
    apply_group(5, 0);
    drain_enter();
    drain_word(0, w);
    drain_word(0, w);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out", out0, 0);
    chk("async_valid", vld0, 0);
    chk("async_full", full0, 0);
    chk("async_complete", cmp0, 0);
    step();
    chk("async_hold_out", out0, 0);
    reset = 1'b0;
    enb   = 1'b0;
    cnt = 0;
    ovf = 1'b0;

    // Empty drain, then resetBuff returns to IDLE and filling works again.
    drain_enter();
    chk("empty_not_yet", cmp0, 0);
    drain_finish(0);
    do_resetbuff();
    apply_group(6, 0);
    drain(0, 2);
    do_resetbuff();

    // Binary edge map on the THRESH=8 instance.
    apply_group(7, 1);
    drain(1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
